// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
// Shadow entries carry a fixed-width wa field so one struct serves any AW up to MAX_AW.
package hazard_pkg;

  localparam int MAX_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] wa;
    logic              regwrite;
    logic              memtoreg;
    logic              pcsrc;
  } shadow_stage_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] maxval);
    return (value >= maxval) ? maxval : value + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_stage.sv
// One shadow pipeline stage: a flat register with synchronous reset and clear.
module hz_stage_reg
  import hazard_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset || i_clear) r_q <= '0;
    else                  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for a 5-stage pipeline; tracks destinations itself
// through a shadow E/M/W pipeline and derives forwarding, stall, flush and event counts.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW     = 4,
  parameter int NREAD  = 2,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREAD*AW-1:0] ra_d,
  input  logic [NREAD-1:0]    ra_used_d,
  input  logic [AW-1:0]       wa_d,
  input  logic                regwrite_d,
  input  logic                memtoreg_d,
  input  logic                pcsrc_d,
  input  logic                branch_taken_e,
  output logic [NREAD*2-1:0]  fwd_sel_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int SW = $bits(shadow_stage_t);
  localparam int EW = SW + NREAD*AW + NREAD;
  localparam logic [AW-1:0] LP_PC = AW'(PC_REG);
  localparam logic [31:0] LP_CMAX = 32'({CNT_W{1'b1}});

  shadow_stage_t       w_d_stage, w_e, w_m, w_w;
  logic [EW-1:0]       w_e_d, w_e_q;
  logic [NREAD*AW-1:0] w_e_ra;
  logic [NREAD-1:0]    w_e_used;
  logic                w_dep, w_ldstall, w_pcpend, w_flush_d, w_flush_e;
  logic                w_unused;
  logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;

  assign w_d_stage = '{valid: 1'b1, wa: MAX_AW'(wa_d), regwrite: regwrite_d,
                       memtoreg: memtoreg_d, pcsrc: pcsrc_d};
  assign w_e_d     = {w_d_stage, ra_d, ra_used_d};
  assign w_e       = w_e_q[EW-1 -: SW];
  assign w_e_ra    = w_e_q[NREAD +: NREAD*AW];
  assign w_e_used  = w_e_q[NREAD-1:0];
  assign w_unused  = ^{w_w.memtoreg, w_w.pcsrc};

  hz_stage_reg #(.W(EW)) u_stage_e (
    .clk(clk), .reset(reset), .i_clear(w_flush_e), .i_d(w_e_d), .o_q(w_e_q)
  );

  hz_stage_reg #(.W(SW)) u_stage_m (
    .clk(clk), .reset(reset), .i_clear(1'b0), .i_d(w_e), .o_q(w_m)
  );

  hz_stage_reg #(.W(SW)) u_stage_w (
    .clk(clk), .reset(reset), .i_clear(1'b0), .i_d(w_m), .o_q(w_w)
  );

  always_comb begin
    w_dep = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      if (ra_used_d[i] && (MAX_AW'(ra_d[i*AW +: AW]) == w_e.wa)) w_dep = 1'b1;
    end
  end

  // A taken branch overrides load-use: the dependent instruction is flushed anyway.
  assign w_ldstall = w_e.valid && w_e.memtoreg && w_e.regwrite && w_dep && !branch_taken_e;
  assign w_pcpend  = pcsrc_d || (w_e.valid && w_e.pcsrc) || (w_m.valid && w_m.pcsrc);
  assign w_flush_d = w_pcpend || branch_taken_e;
  assign w_flush_e = w_ldstall || branch_taken_e;

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_fwd
    logic [AW-1:0] w_ra;
    logic          w_rd_ok, w_hit_m, w_hit_w;

    assign w_ra    = w_e_ra[gi*AW +: AW];
    assign w_rd_ok = w_e_used[gi] && (w_ra != LP_PC);
    assign w_hit_m = w_rd_ok && w_m.valid && w_m.regwrite && (w_m.wa == MAX_AW'(w_ra));
    assign w_hit_w = w_rd_ok && w_w.valid && w_w.regwrite && (w_w.wa == MAX_AW'(w_ra));
    assign fwd_sel_e[gi*2 +: 2] = reset   ? FWD_RF :
                                  w_hit_m ? FWD_M  :
                                  w_hit_w ? FWD_W  : FWD_RF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_ldstall) r_stall_cnt <= CNT_W'(sat_inc(32'(r_stall_cnt), LP_CMAX));
      if (w_flush_d) r_flush_cnt <= CNT_W'(sat_inc(32'(r_flush_cnt), LP_CMAX));
    end
  end

  assign stall_f   = !reset && (w_ldstall || w_pcpend);
  assign stall_d   = !reset && w_ldstall;
  assign flush_d   = !reset && w_flush_d;
  assign flush_e   = !reset && w_flush_e;
  assign stall_cnt = reset ? '0 : r_stall_cnt;
  assign flush_cnt = reset ? '0 : r_flush_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two configurations (2-read/16-bit and 3-read/2-bit counters) share
// one stimulus stream; a reference model queues expectations, a monitor checks them.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic        v;
    logic [3:0]  wa;
    logic        rw;
    logic        mt;
    logic        pc;
    logic [11:0] ra;
    logic [2:0]  used;
  } instr_t;

  typedef struct packed {
    logic        d;
    logic [5:0]  fwd;
    logic        sf;
    logic        sd;
    logic        fd;
    logic        fe;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] ra0, ra1, ra2, wa;
  logic [2:0] used;
  logic rw, mt, pcs, bt;

  logic [3:0]  fwd0;
  logic        sf0, sd0, fd0, fe0;
  logic [15:0] sc0, fc0;
  logic [5:0]  fwd1;
  logic        sf1, sd1, fd1, fe1;
  logic [1:0]  sc1, fc1;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  exp_t expq[$];

  instr_t mE[2];
  instr_t mM[2];
  instr_t mW[2];
  int     mSc[2];
  int     mFc[2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(4), .NREAD(2), .PC_REG(15), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst), .ra_d({ra1, ra0}), .ra_used_d(used[1:0]), .wa_d(wa),
    .regwrite_d(rw), .memtoreg_d(mt), .pcsrc_d(pcs), .branch_taken_e(bt),
    .fwd_sel_e(fwd0), .stall_f(sf0), .stall_d(sd0), .flush_d(fd0), .flush_e(fe0),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  hazard_scoreboard #(.AW(4), .NREAD(3), .PC_REG(15), .CNT_W(2)) dut1 (
    .clk(clk), .reset(rst), .ra_d({ra2, ra1, ra0}), .ra_used_d(used), .wa_d(wa),
    .regwrite_d(rw), .memtoreg_d(mt), .pcsrc_d(pcs), .branch_taken_e(bt),
    .fwd_sel_e(fwd1), .stall_f(sf1), .stall_d(sd1), .flush_d(fd1), .flush_e(fe1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  task automatic checkField(input string name, input int d, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cycle, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t x);
    if (x.d == 1'b0) begin
      checkField("fwd_sel_e", 0, int'(fwd0), int'(x.fwd[3:0]));
      checkField("stall_f", 0, int'(sf0), int'(x.sf));
      checkField("stall_d", 0, int'(sd0), int'(x.sd));
      checkField("flush_d", 0, int'(fd0), int'(x.fd));
      checkField("flush_e", 0, int'(fe0), int'(x.fe));
      checkField("stall_cnt", 0, int'(sc0), int'(x.sc));
      checkField("flush_cnt", 0, int'(fc0), int'(x.fc));
    end else begin
      checkField("fwd_sel_e", 1, int'(fwd1), int'(x.fwd));
      checkField("stall_f", 1, int'(sf1), int'(x.sf));
      checkField("stall_d", 1, int'(sd1), int'(x.sd));
      checkField("flush_d", 1, int'(fd1), int'(x.fd));
      checkField("flush_e", 1, int'(fe1), int'(x.fe));
      checkField("stall_cnt", 1, int'(sc1), int'(x.sc));
      checkField("flush_cnt", 1, int'(fc1), int'(x.fc));
    end
  endtask

  // Drive one decode cycle, predict both DUTs' outputs for it, then advance the model.
  task automatic applyStimulus(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                               input logic [2:0] u, input logic [3:0] w, input logic rwv,
                               input logic mtv, input logic pcv, input logic btv, input logic rstv);
    logic [3:0] rd[3];
    @(posedge clk);
    #1;
    ra0 = a0; ra1 = a1; ra2 = a2; used = u; wa = w;
    rw = rwv; mt = mtv; pcs = pcv; bt = btv; rst = rstv;
    rd[0] = a0; rd[1] = a1; rd[2] = a2;
    cycle++;
    for (int d = 0; d < 2; d++) begin
      int     nr;
      int     cmax;
      instr_t e, m, ws, ni;
      logic   dep, ld, pcp, fdv, fev;
      logic [3:0] r;
      logic [1:0] sel;
      exp_t   x;
      nr   = (d == 0) ? 2 : 3;
      cmax = (d == 0) ? 65535 : 3;
      e = mE[d]; m = mM[d]; ws = mW[d];
      dep = 1'b0;
      for (int i = 0; i < nr; i++) if (u[i] && rd[i] == e.wa) dep = 1'b1;
      ld  = e.v && e.mt && e.rw && dep && !btv;
      pcp = pcv || (e.v && e.pc) || (m.v && m.pc);
      fdv = pcp || btv;
      fev = ld || btv;
      x = '0;
      x.d = d[0];
      if (!rstv) begin
        x.sf = ld || pcp;
        x.sd = ld;
        x.fd = fdv;
        x.fe = fev;
        x.sc = 16'(mSc[d]);
        x.fc = 16'(mFc[d]);
        for (int i = 0; i < nr; i++) begin
          r = e.ra[i*4 +: 4];
          sel = 2'b00;
          if (e.used[i] && r != 4'd15) begin
            if (m.v && m.rw && m.wa == r) sel = 2'b10;
            else if (ws.v && ws.rw && ws.wa == r) sel = 2'b01;
          end
          x.fwd[i*2 +: 2] = sel;
        end
      end
      expq.push_back(x);
      if (rstv) begin
        mE[d] = '0; mM[d] = '0; mW[d] = '0; mSc[d] = 0; mFc[d] = 0;
      end else begin
        if (ld)  mSc[d] = (mSc[d] >= cmax) ? cmax : mSc[d] + 1;
        if (fdv) mFc[d] = (mFc[d] >= cmax) ? cmax : mFc[d] + 1;
        ni = '0;
        ni.v = 1'b1; ni.wa = w; ni.rw = rwv; ni.mt = mtv; ni.pc = pcv;
        ni.ra = {a2, a1, a0}; ni.used = u;
        mW[d] = m;
        mM[d] = e;
        mE[d] = fev ? '0 : ni;
      end
    end
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [3:0] pickReg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  initial begin
    rst = 1'b1; ra0 = 0; ra1 = 0; ra2 = 0; used = 0; wa = 0;
    rw = 0; mt = 0; pcs = 0; bt = 0;
    for (int d = 0; d < 2; d++) begin
      mE[d] = '0; mM[d] = '0; mW[d] = '0; mSc[d] = 0; mFc[d] = 0;
    end
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 2, 3, 3'b111, 4, 1, 1, 1, 1, 1);

    // ADD r1 then SUB r2,r1,r3
    applyStimulus(0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 3, 0, 3'b011, 2, 1, 0, 0, 0, 0);
    nop(3);
    // ADD r1, NOP, ORR r4,r1,r1; then same wa in M and W
    applyStimulus(0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0);
    nop(1);
    applyStimulus(1, 1, 0, 3'b011, 4, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 3'b000, 7, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 3'b000, 7, 1, 0, 0, 0, 0);
    applyStimulus(7, 7, 7, 3'b111, 8, 1, 0, 0, 0, 0);
    nop(3);
    // LDR r5 then dependent ADD, held for one stall cycle
    applyStimulus(0, 0, 0, 3'b000, 5, 1, 1, 0, 0, 0);
    applyStimulus(5, 0, 0, 3'b011, 6, 1, 0, 0, 0, 0);
    applyStimulus(5, 0, 0, 3'b011, 6, 1, 0, 0, 0, 0);
    nop(3);
    // load-use coinciding with a taken branch
    applyStimulus(0, 0, 0, 3'b000, 5, 1, 1, 0, 0, 0);
    applyStimulus(5, 0, 0, 3'b011, 6, 1, 0, 0, 1, 0);
    nop(3);
    // LDR r15 redirects the PC; reads of r15 never forward
    applyStimulus(0, 0, 0, 3'b000, 15, 1, 1, 1, 0, 0);
    applyStimulus(15, 15, 15, 3'b111, 3, 1, 0, 0, 0, 0);
    nop(4);
    // repeated load-use stalls saturate the narrow counter, then reset mid-stall
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 3'b000, 1, 1, 1, 0, 0, 0);
      applyStimulus(9, 8, 1, 3'b111, 2, 1, 0, 0, 0, 0);
      applyStimulus(1, 8, 9, 3'b111, 2, 1, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 3'b000, 1, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 3'b001, 2, 1, 0, 0, 0, 1);
    nop(3);

    for (int k = 0; k < 800; k++) begin
      applyStimulus(pickReg(), pickReg(), pickReg(), 3'($urandom_range(0, 7)), pickReg(),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 59) == 0));
    end

    for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
